// File: rtl/decode_stage.sv
// RV32I decode stage: one skid-free pipeline register with valid/ready handshake, a
// combinational opcode-class and immediate decoder on the held instruction.
module decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [4:0]      addr_rs1_o,
  output logic [4:0]      addr_rs2_o,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [4:0]      id_rd_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [3:0]      id_op_o,
  output logic            id_illegal_o
);

  localparam logic [3:0] OpLui     = 4'd0;
  localparam logic [3:0] OpAuipc   = 4'd1;
  localparam logic [3:0] OpJal     = 4'd2;
  localparam logic [3:0] OpJalr    = 4'd3;
  localparam logic [3:0] OpBranch  = 4'd4;
  localparam logic [3:0] OpLoad    = 4'd5;
  localparam logic [3:0] OpStore   = 4'd6;
  localparam logic [3:0] OpOpImm   = 4'd7;
  localparam logic [3:0] OpOp      = 4'd8;
  localparam logic [3:0] OpMiscMem = 4'd9;
  localparam logic [3:0] OpSystem  = 4'd10;
  localparam logic [3:0] OpIllegal = 4'd15;

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            load_en;

  assign if_ready_o = !valid_q || id_ready_i;
  assign accept     = if_valid_i && if_ready_o;
  // A flushed offer is dropped entirely, so the held fields stay untouched.
  assign load_en    = accept && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (valid_q && id_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      instr_q <= InstrNop;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        instr_q <= if_instr_i;
        pc_q    <= if_pc_i;
      end
    end
  end

  // Regfile has one cycle of read latency: address the incoming instruction when it can
  // be accepted, otherwise keep addressing the held one so data stays aligned in a stall.
  always_comb begin
    if (if_ready_o) begin
      addr_rs1_o = if_instr_i[19:15];
      addr_rs2_o = if_instr_i[24:20];
    end else begin
      addr_rs1_o = instr_q[19:15];
      addr_rs2_o = instr_q[24:20];
    end
  end

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                  instr_q[30:21], 1'b0};

  always_comb begin
    id_op_o      = OpIllegal;
    id_illegal_o = 1'b1;
    id_rd_o      = 5'd0;
    imm32        = 32'd0;
    unique case (instr_q[6:0])
      7'b0110111: begin id_op_o = OpLui;     id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_u; end
      7'b0010111: begin id_op_o = OpAuipc;   id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_u; end
      7'b1101111: begin id_op_o = OpJal;     id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_j; end
      7'b1100111: begin id_op_o = OpJalr;    id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_i; end
      7'b1100011: begin id_op_o = OpBranch;  id_illegal_o = 1'b0; imm32 = imm_b; end
      7'b0000011: begin id_op_o = OpLoad;    id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_i; end
      7'b0100011: begin id_op_o = OpStore;   id_illegal_o = 1'b0; imm32 = imm_s; end
      7'b0010011: begin id_op_o = OpOpImm;   id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_i; end
      7'b0110011: begin id_op_o = OpOp;      id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; end
      7'b0001111: begin id_op_o = OpMiscMem; id_illegal_o = 1'b0; imm32 = imm_i; end
      7'b1110011: begin id_op_o = OpSystem;  id_illegal_o = 1'b0; id_rd_o = instr_q[11:7]; imm32 = imm_i; end
      default: ;
    endcase
  end

  assign id_imm_o   = XLEN'($signed(imm32));
  assign id_valid_o = valid_q;
  assign id_pc_o    = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, stall alignment, immediate decode, flush and
// asynchronous reset, each checked against hand-computed values.
module tb_decode_stage;

  logic        clk_i;
  logic        rst_n_i;
  logic        flush_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic [4:0]  addr_rs1_o;
  logic [4:0]  addr_rs2_o;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [4:0]  id_rd_o;
  logic [31:0] id_imm_o;
  logic [3:0]  id_op_o;
  logic        id_illegal_o;

  int vectors;
  int errors;

  decode_stage #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .if_valid_i  (if_valid_i),
    .if_ready_o  (if_ready_o),
    .if_instr_i  (if_instr_i),
    .if_pc_i     (if_pc_i),
    .addr_rs1_o  (addr_rs1_o),
    .addr_rs2_o  (addr_rs2_o),
    .id_valid_o  (id_valid_o),
    .id_ready_i  (id_ready_i),
    .id_pc_o     (id_pc_o),
    .id_rd_o     (id_rd_o),
    .id_imm_o    (id_imm_o),
    .id_op_o     (id_op_o),
    .id_illegal_o(id_illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Offer one instruction for a single cycle, then go idle; held outputs visible at the
  // following negedge.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    @(posedge clk_i); #1;
    if_valid_i = 1'b1; if_instr_i = instr; if_pc_i = pc;
    @(posedge clk_i); #1;
    if_valid_i = 1'b0; if_instr_i = 32'h0000_0013;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0; id_ready_i = 1'b1;
    if_instr_i = 32'h0000_0013; if_pc_i = '0;
    repeat (2) @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid_o); end
    vectors++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if_ready_o); end
    vectors++; if (id_op_o !== 4'd7) begin errors++; $display("FAIL reset_op: got %0d want 7", id_op_o); end
    vectors++; if (id_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", id_rd_o); end
    vectors++; if (id_imm_o !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", id_imm_o); end
    vectors++; if (id_illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", id_illegal_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_accept_consume();
    @(posedge clk_i); #1;
    id_ready_i = 1'b1; if_valid_i = 1'b1; if_instr_i = 32'h0050_0093; if_pc_i = 32'h100;
    @(negedge clk_i);
    vectors++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL acc_ready: got %b want 1", if_ready_o); end
    vectors++; if (addr_rs1_o !== 5'd0) begin errors++; $display("FAIL acc_rs1: got %0d want 0", addr_rs1_o); end
    vectors++; if (addr_rs2_o !== 5'd5) begin errors++; $display("FAIL acc_rs2: got %0d want 5", addr_rs2_o); end
    @(posedge clk_i); #1;
    if_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL acc_valid: got %b want 1", id_valid_o); end
    vectors++; if (id_op_o !== 4'd7) begin errors++; $display("FAIL acc_op: got %0d want 7", id_op_o); end
    vectors++; if (id_rd_o !== 5'd1) begin errors++; $display("FAIL acc_rd: got %0d want 1", id_rd_o); end
    vectors++; if (id_imm_o !== 32'd5) begin errors++; $display("FAIL acc_imm: got %h want 5", id_imm_o); end
    vectors++; if (id_pc_o !== 32'h100) begin errors++; $display("FAIL acc_pc: got %h want 100", id_pc_o); end
    @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL acc_consumed: got %b want 0", id_valid_o); end
  endtask

  task automatic test_stall_back_to_back();
    @(posedge clk_i); #1;
    id_ready_i = 1'b0; if_valid_i = 1'b1; if_instr_i = 32'h0020_81B3; if_pc_i = 32'h104;
    @(posedge clk_i); #1;
    if_instr_i = 32'h0000_0013; if_pc_i = 32'h108;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      vectors++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", i, if_ready_o); end
      vectors++; if (addr_rs1_o !== 5'd1) begin errors++; $display("FAIL stall_rs1[%0d]: got %0d want 1", i, addr_rs1_o); end
      vectors++; if (addr_rs2_o !== 5'd2) begin errors++; $display("FAIL stall_rs2[%0d]: got %0d want 2", i, addr_rs2_o); end
      vectors++; if (id_op_o !== 4'd8 || id_rd_o !== 5'd3 || id_imm_o !== 32'h0 || id_pc_o !== 32'h104)
        begin errors++; $display("FAIL stall_held[%0d]: got op=%0d rd=%0d imm=%h pc=%h want op=8 rd=3 imm=0 pc=104",
                                 i, id_op_o, id_rd_o, id_imm_o, id_pc_o); end
      @(posedge clk_i); #1;
    end
    // Release: consume and accept on the same edge, no bubble.
    id_ready_i = 1'b1;
    @(negedge clk_i);
    vectors++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", if_ready_o); end
    @(posedge clk_i); #1;
    if_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h108 || id_op_o !== 4'd7)
      begin errors++; $display("FAIL b2b_next: got v=%b pc=%h op=%0d want v=1 pc=108 op=7", id_valid_o, id_pc_o, id_op_o); end
  endtask

  task automatic test_immediates();
    offer(32'hFE00_08E3, 32'h200);
    vectors++; if (id_op_o !== 4'd4) begin errors++; $display("FAIL beq_op: got %0d want 4", id_op_o); end
    vectors++; if (id_imm_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL beq_imm: got %h want fffffff0", id_imm_o); end
    vectors++; if (id_rd_o !== 5'd0) begin errors++; $display("FAIL beq_rd: got %0d want 0", id_rd_o); end
    offer(32'h8000_00EF, 32'h204);
    vectors++; if (id_op_o !== 4'd2) begin errors++; $display("FAIL jal_op: got %0d want 2", id_op_o); end
    vectors++; if (id_imm_o !== 32'hFFF0_0000) begin errors++; $display("FAIL jal_imm: got %h want fff00000", id_imm_o); end
    vectors++; if (id_rd_o !== 5'd1) begin errors++; $display("FAIL jal_rd: got %0d want 1", id_rd_o); end
    offer(32'hFE11_2E23, 32'h208);
    vectors++; if (id_op_o !== 4'd6 || id_imm_o !== 32'hFFFF_FFFC || id_rd_o !== 5'd0)
      begin errors++; $display("FAIL sw: got op=%0d imm=%h rd=%0d want op=6 imm=fffffffc rd=0", id_op_o, id_imm_o, id_rd_o); end
    offer(32'hABCD_E0B7, 32'h20C);
    vectors++; if (id_op_o !== 4'd0 || id_imm_o !== 32'hABCD_E000 || id_rd_o !== 5'd1)
      begin errors++; $display("FAIL lui: got op=%0d imm=%h rd=%0d want op=0 imm=abcde000 rd=1", id_op_o, id_imm_o, id_rd_o); end
  endtask

  task automatic test_illegal();
    offer(32'hFFFF_FFFF, 32'h300);
    vectors++; if (id_illegal_o !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", id_illegal_o); end
    vectors++; if (id_op_o !== 4'd15) begin errors++; $display("FAIL ill_op: got %0d want 15", id_op_o); end
    vectors++; if (id_rd_o !== 5'd0) begin errors++; $display("FAIL ill_rd: got %0d want 0", id_rd_o); end
    vectors++; if (id_imm_o !== 32'h0) begin errors++; $display("FAIL ill_imm: got %h want 0", id_imm_o); end
  endtask

  task automatic test_flush();
    offer(32'h0050_0093, 32'h400);
    vectors++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b want 1", id_valid_o); end
    @(posedge clk_i); #1;
    id_ready_i = 1'b0;
    @(posedge clk_i); #1;
    id_ready_i = 1'b1; flush_i = 1'b1; if_valid_i = 1'b1; if_instr_i = 32'hFFFF_FFFF; if_pc_i = 32'h404;
    @(negedge clk_i);
    vectors++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", if_ready_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; if_valid_i = 1'b0; if_instr_i = 32'h0000_0013;
    @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", id_valid_o); end
    vectors++; if (id_illegal_o !== 1'b0 || id_pc_o !== 32'h400)
      begin errors++; $display("FAIL flush_nocapture: got ill=%b pc=%h want ill=0 pc=400", id_illegal_o, id_pc_o); end
  endtask

  task automatic test_async_reset();
    @(posedge clk_i); #1;
    id_ready_i = 1'b0; if_valid_i = 1'b1; if_instr_i = 32'h0020_81B3; if_pc_i = 32'h500;
    @(posedge clk_i); #1;
    if_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (id_valid_o !== 1'b1 || if_ready_o !== 1'b0)
      begin errors++; $display("FAIL ares_pre: got v=%b r=%b want v=1 r=0", id_valid_o, if_ready_o); end
    #1 rst_n_i = 1'b0;
    #1;
    vectors++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL ares_valid: got %b want 0", id_valid_o); end
    vectors++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL ares_ready: got %b want 1", if_ready_o); end
    vectors++; if (id_op_o !== 4'd7 || id_pc_o !== 32'h0)
      begin errors++; $display("FAIL ares_held: got op=%0d pc=%h want op=7 pc=0", id_op_o, id_pc_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1; id_ready_i = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_accept_consume();
    test_stall_back_to_back();
    test_immediates();
    test_illegal();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
